// File: rtl/mmu_responder.sv
// Memory-side responder for the CPU MMU port: word-organised RAM with byte/half/word
// access, sign/zero-extended reads, programmable wait states and a one-cycle ready pulse.

`ifndef MMU_WIDTH_BYTE
`define MMU_WIDTH_BYTE 2'b00
`endif
`ifndef MMU_WIDTH_HALF
`define MMU_WIDTH_HALF 2'b01
`endif
`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'b10
`endif

// One byte lane: decides whether this lane is written and which data byte lands in it.
module mmu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic        we,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = LANE[1:0];

  // Each lane only looks at a subset of the write data.
  logic unused_data;
  assign unused_data = ^data;

  always_comb begin
    we    = 1'b1;
    wbyte = data[8*LANE +: 8];
    case (width)
      `MMU_WIDTH_BYTE: begin
        we    = (addr_lo == L);
        wbyte = data[7:0];
      end
      `MMU_WIDTH_HALF: begin
        we    = (addr_lo[1] == L[1]);
        wbyte = data[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module mmu_responder #(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmu_read_enable,
  input  logic        mmu_write_enable,
  input  logic        mmu_mem_signed_read,
  input  logic [1:0]  mmu_mem_data_width,
  input  logic [31:0] mmu_address,
  input  logic [31:0] mmu_data_in,
  output logic        mmu_mem_ready,
  output logic [31:0] mmu_data_out
);
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESPOND} state_t;

  typedef struct packed {
    logic                  write;
    logic                  sgn;
    logic [1:0]            width;
    logic [ADDR_WIDTH+1:0] addr;
    logic [31:0]           data;
  } req_t;

  state_t                         state, state_n;
  req_t                           req;
  logic [CW-1:0]                  cnt;
  logic [NUM_LANES-1:0][7:0]      rword;
  logic [NUM_LANES-1:0][7:0]      mem [DEPTH];
  logic [NUM_LANES-1:0]           lane_we;
  logic [NUM_LANES-1:0][7:0]      lane_wb;
  logic [31:0]                    rd_ext;
  logic [ADDR_WIDTH-1:0]          idx;
  logic                           accept;

  // Address bits above the RAM depth alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^mmu_address[31:ADDR_WIDTH+2];

  assign accept = mmu_read_enable | mmu_write_enable;
  assign idx    = req.addr[ADDR_WIDTH+1:2];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mmu_lane #(.LANE(l)) u_lane (
      .width  (req.width),
      .addr_lo(req.addr[1:0]),
      .data   (req.data),
      .we     (lane_we[l]),
      .wbyte  (lane_wb[l])
    );
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (accept) state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:    if (cnt == '0) state_n = S_ACCESS;
      S_ACCESS:  state_n = S_RESPOND;
      S_RESPOND: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rword[req.addr[1:0]];
    h = req.addr[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
    case (req.width)
      `MMU_WIDTH_BYTE: rd_ext = {{24{req.sgn & b[7]}}, b};
      `MMU_WIDTH_HALF: rd_ext = {{16{req.sgn & h[15]}}, h};
      default:         rd_ext = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mmu_mem_ready <= 1'b0;
      mmu_data_out  <= '0;
    end else begin
      state         <= state_n;
      // Ready is registered out of RESPOND so it lines up with the next IDLE sample edge.
      mmu_mem_ready <= (state == S_RESPOND);
      if (state == S_IDLE && accept) begin
        req.write <= mmu_write_enable;
        req.sgn   <= mmu_mem_signed_read;
        req.width <= mmu_mem_data_width;
        req.addr  <= mmu_address[ADDR_WIDTH+1:0];
        req.data  <= mmu_data_in;
        cnt       <= CNT_LOAD;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_RESPOND && !req.write) mmu_data_out <= rd_ext;
    end
  end

  // RAM port: per-byte write enables, registered read.
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS) begin
      if (req.write)
        for (int l = 0; l < NUM_LANES; l++)
          if (lane_we[l]) mem[idx][l] <= lane_wb[l];
      rword <= mem[idx];
    end
  end
endmodule

// File: tb/tb_mmu_responder.sv
// Directed bench for mmu_responder: vector table on a WAIT_CYCLES=2 instance, plus
// reset-abandon and held-read sequences (the latter on a WAIT_CYCLES=0 instance).
module tb_mmu_responder;
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        sgn;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  req_t        q2 = '0, q0 = '0;
  logic        rdy2, rdy0;
  logic [31:0] dout2, dout0;
  int          total = 0, bad = 0;
  vec_t        vt[$];

  always #5 clk = ~clk;

  mmu_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .mmu_read_enable(q2.rd), .mmu_write_enable(q2.wr), .mmu_mem_signed_read(q2.sgn),
    .mmu_mem_data_width(q2.w), .mmu_address(q2.a), .mmu_data_in(q2.d),
    .mmu_mem_ready(rdy2), .mmu_data_out(dout2)
  );

  mmu_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .mmu_read_enable(q0.rd), .mmu_write_enable(q0.wr), .mmu_mem_signed_read(q0.sgn),
    .mmu_mem_data_width(q0.w), .mmu_address(q0.a), .mmu_data_in(q0.d),
    .mmu_mem_ready(rdy0), .mmu_data_out(dout0)
  );

  function automatic req_t mk(input logic rd, input logic wr, input logic sgn,
                              input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.sgn = sgn; r.w = w; r.a = a; r.d = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic addv(input req_t r, input logic [31:0] exp, input string nm);
    vec_t v;
    v.r = r; v.exp = exp; v.nm = nm;
    vt.push_back(v);
  endtask

  // One transaction: checks ready latency (WAIT_CYCLES+2 edges after accept), data at
  // the ready pulse, and that the pulse is one cycle wide. Inputs are scrambled after accept.
  task automatic xact(input bit sel0, input req_t r, input logic [31:0] exp, input string nm);
    int          lat;
    logic [31:0] d;
    req_t        s;
    lat = -1;
    d   = 'x;
    @(negedge clk);
    if (sel0) q0 = r; else q2 = r;
    @(posedge clk);
    #1;
    s = r; s.rd = 1'b0; s.wr = 1'b0; s.a = ~r.a; s.d = ~r.d; s.sgn = ~r.sgn; s.w = ~r.w;
    if (sel0) q0 = s; else q2 = s;
    for (int n = 0; n < 12 && lat < 0; n++) begin
      @(negedge clk);
      if ((sel0 ? rdy0 : rdy2) === 1'b1) begin
        lat = n;
        d   = sel0 ? dout0 : dout2;
      end
    end
    chk({nm, " latency"}, lat, sel0 ? 32'd2 : 32'd4);
    chk({nm, " data"}, d, exp);
    @(negedge clk);
    chk({nm, " pulse"}, {31'd0, sel0 ? rdy0 : rdy2}, 32'd0);
  endtask

  initial begin
    int          seen, idx;
    logic [31:0] pre [3];

    // width codes: 0=byte 1=half 2=word 3=word
    addv(mk(0,1,0,2'd2,32'h10,  32'hDEADBEEF), 32'h00000000, "wr word 10");
    addv(mk(1,0,0,2'd2,32'h10,  32'h0),        32'hDEADBEEF, "rd word 10");
    addv(mk(0,1,0,2'd2,32'h10,  32'h00000000), 32'hDEADBEEF, "clr word 10");
    addv(mk(0,1,0,2'd0,32'h11,  32'hFFFFFF80), 32'hDEADBEEF, "wr byte 11");
    addv(mk(1,0,1,2'd0,32'h11,  32'h0),        32'hFFFFFF80, "rd sbyte 11");
    addv(mk(1,0,0,2'd0,32'h11,  32'h0),        32'h00000080, "rd ubyte 11");
    addv(mk(1,0,0,2'd2,32'h10,  32'h0),        32'h00008000, "rd word 10 b");
    addv(mk(1,0,1,2'd1,32'h10,  32'h0),        32'hFFFF8000, "rd shalf 10");
    addv(mk(0,1,0,2'd2,32'h20,  32'h11111111), 32'hFFFF8000, "wr word 20");
    addv(mk(0,1,0,2'd1,32'h22,  32'hAAAAF00D), 32'hFFFF8000, "wr half 22");
    addv(mk(1,0,0,2'd2,32'h20,  32'h0),        32'hF00D1111, "rd word 20");
    addv(mk(1,0,1,2'd1,32'h22,  32'h0),        32'hFFFFF00D, "rd shalf 22");
    addv(mk(1,0,0,2'd1,32'h23,  32'h0),        32'h0000F00D, "rd uhalf 23");
    addv(mk(1,0,1,2'd0,32'h21,  32'h0),        32'h00000011, "rd sbyte 21");
    addv(mk(1,0,1,2'd3,32'h20,  32'h0),        32'hF00D1111, "rd w11 20");
    addv(mk(0,1,0,2'd0,32'h13,  32'h0000005A), 32'hF00D1111, "wr byte 13");
    addv(mk(1,0,0,2'd2,32'h10,  32'h0),        32'h5A008000, "rd word 10 c");
    addv(mk(1,1,0,2'd2,32'h4000,32'hCAFEBABE), 32'h5A008000, "rd+wr 4000");
    addv(mk(1,0,0,2'd2,32'h0,   32'h0),        32'hCAFEBABE, "rd alias 0");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rdy2", {31'd0, rdy2}, 32'd0);
    chk("reset dout2", dout2, 32'd0);
    chk("reset rdy0", {31'd0, rdy0}, 32'd0);
    chk("reset dout0", dout0, 32'd0);
    reset = 1'b0;

    foreach (vt[i]) xact(1'b0, vt[i].r, vt[i].exp, vt[i].nm);

    // Write abandoned by reset while waiting: no ready, data_out cleared, RAM intact.
    xact(1'b0, mk(0,1,0,2'd2,32'h30,32'hA5A5A5A5), 32'hCAFEBABE, "wr word 30");
    @(negedge clk);
    q2 = mk(0,1,0,2'd2,32'h30,32'h12345678);
    @(posedge clk);
    #1 q2 = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rdy2 === 1'b1) seen++;
    end
    chk("abandon no ready", seen, 32'd0);
    chk("abandon dout", dout2, 32'd0);
    xact(1'b0, mk(1,0,0,2'd2,32'h30,32'h0), 32'hA5A5A5A5, "abandon rd 30");

    // Held read on the zero-wait instance: one access per ready, every 3 cycles.
    pre[0] = 32'h11223344; pre[1] = 32'h55667788; pre[2] = 32'h99AABBCC;
    for (int i = 0; i < 3; i++)
      xact(1'b1, mk(0,1,0,2'd2,32'(i*4),pre[i]), 32'h0, "wr0 pre");
    @(negedge clk);
    q0 = mk(1,0,0,2'd2,32'h0,32'h0);
    idx = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy0 === 1'b1) begin
        chk("held ready slot", n, 32'(3*idx + 2));
        if (idx < 3) chk("held data", dout0, pre[idx]);
        idx++;
        if (idx < 3) q0.a = 32'(idx*4);
        else q0.rd = 1'b0;
      end
    end
    chk("held ready count", idx, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
